ay8910: RTL and testbench

Programmable sound generator compatible with the AY-3-8910, driven by the memory/port router's AY interface (`ay_reg`, `ay_data_o`, `ay_data_i`, `ay_req`). It holds the 16 PSG registers and generates three square-wave tone channels, one shared noise source and one envelope generator. It emits a 10-bit unsigned mixed PCM sample for the downstream audio DAC stage. Internally it runs at 1.75 MHz, produced by a fractional clock enable derived from the system clock.

---
 rtl/ay_pkg.sv | 57 +++++
 rtl/ay_envelope.sv | 53 +++++
 rtl/ay8910.sv | 123 ++++++++++++
 tb/tb_ay8910.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ay_pkg.sv
// ay_pkg: register map, readback masks, DAC table and envelope shape bits for the AY-3-8910 PSG
package ay_pkg;
    localparam logic [3:0] AY_TONE_A_L  = 4'd0;
    localparam logic [3:0] AY_TONE_A_H  = 4'd1;
    localparam logic [3:0] AY_TONE_B_L  = 4'd2;
    localparam logic [3:0] AY_TONE_B_H  = 4'd3;
    localparam logic [3:0] AY_TONE_C_L  = 4'd4;
    localparam logic [3:0] AY_TONE_C_H  = 4'd5;
    localparam logic [3:0] AY_NOISE     = 4'd6;
    localparam logic [3:0] AY_MIXER     = 4'd7;
    localparam logic [3:0] AY_AMP_A     = 4'd8;
    localparam logic [3:0] AY_AMP_B     = 4'd9;
    localparam logic [3:0] AY_AMP_C     = 4'd10;
    localparam logic [3:0] AY_ENV_L     = 4'd11;
    localparam logic [3:0] AY_ENV_H     = 4'd12;
    localparam logic [3:0] AY_ENV_SHAPE = 4'd13;
    localparam logic [3:0] AY_IO_A      = 4'd14;
    localparam logic [3:0] AY_IO_B      = 4'd15;

    localparam int SHAPE_HOLD = 0;
    localparam int SHAPE_ALT  = 1;
    localparam int SHAPE_ATT  = 2;
    localparam int SHAPE_CONT = 3;

    // Bits that exist in each register; the rest read back as zero
    function automatic logic [7:0] ay_mask(input logic [3:0] idx);
        case (idx)
            AY_TONE_A_H, AY_TONE_B_H, AY_TONE_C_H, AY_ENV_SHAPE: ay_mask = 8'h0F;
            AY_NOISE, AY_AMP_A, AY_AMP_B, AY_AMP_C:              ay_mask = 8'h1F;
            AY_MIXER:                                            ay_mask = 8'h3F;
            AY_IO_A, AY_IO_B:                                    ay_mask = 8'h00;
            default:                                             ay_mask = 8'hFF;
        endcase
    endfunction

    // Logarithmic volume curve, roughly 3 dB per step
    function automatic logic [7:0] ay_dac(input logic [3:0] v);
        case (v)
            4'd0:    ay_dac = 8'd0;
            4'd1:    ay_dac = 8'd2;
            4'd2:    ay_dac = 8'd3;
            4'd3:    ay_dac = 8'd4;
            4'd4:    ay_dac = 8'd6;
            4'd5:    ay_dac = 8'd8;
            4'd6:    ay_dac = 8'd11;
            4'd7:    ay_dac = 8'd16;
            4'd8:    ay_dac = 8'd23;
            4'd9:    ay_dac = 8'd32;
            4'd10:   ay_dac = 8'd45;
            4'd11:   ay_dac = 8'd64;
            4'd12:   ay_dac = 8'd90;
            4'd13:   ay_dac = 8'd128;
            4'd14:   ay_dac = 8'd181;
            default: ay_dac = 8'd255;
        endcase
    endfunction
endpackage

// File: rtl/ay_envelope.sv
// ay_envelope: envelope period counter plus step/direction/hold shape sequencing
module ay_envelope
    import ay_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_tick16,
    input  logic [15:0] i_period,
    input  logic [3:0]  i_shape,
    input  logic        i_restart,
    output logic [3:0]  o_level
);
    logic [15:0] r_cnt;
    logic [3:0]  r_step;
    logic        r_dir;
    logic        r_hold;
    logic [15:0] w_max;
    logic        w_wrap;

    assign w_max   = (i_period == 16'd0) ? 16'd1 : i_period;
    assign w_wrap  = i_tick16 && ({1'b0, r_cnt} + 17'd1 >= {1'b0, w_max});
    assign o_level = r_dir ? r_step : ~r_step;

    // Period counter runs freely; holding is expressed by parking step at 15 with dir chosen for the final level
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_step <= '0;
            r_dir  <= 1'b0;
            r_hold <= 1'b0;
        end else begin
            if (i_tick16) r_cnt <= w_wrap ? 16'd0 : r_cnt + 16'd1;
            if (i_restart) begin
                r_step <= '0;
                r_dir  <= i_shape[SHAPE_ATT];
                r_hold <= 1'b0;
            end else if (w_wrap && !r_hold) begin
                if (r_step != 4'd15) begin
                    r_step <= r_step + 4'd1;
                end else if (!i_shape[SHAPE_CONT]) begin
                    r_hold <= 1'b1;
                    r_dir  <= 1'b0;
                end else if (i_shape[SHAPE_HOLD]) begin
                    r_hold <= 1'b1;
                    r_dir  <= r_dir ^ i_shape[SHAPE_ALT];
                end else begin
                    r_step <= '0;
                    r_dir  <= r_dir ^ i_shape[SHAPE_ALT];
                end
            end
        end
    end
endmodule

// File: rtl/ay8910.sv
// ay8910: AY-3-8910 compatible PSG with three tones, noise, envelope and a 10-bit mixed PCM output
module ay8910
    import ay_pkg::*;
#(
    parameter int FREQ = 7,
    parameter int FREF = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] ay_reg,
    input  logic [7:0] ay_data_o,
    input  logic       ay_req,
    output logic [7:0] ay_data_i,
    output logic [9:0] pcm
);
    logic [7:0]  r_regs [16];
    logic [15:0] r_acc;
    logic [3:0]  r_pre;
    logic [11:0] r_tcnt [3];
    logic [2:0]  r_tone;
    logic [4:0]  r_ncnt;
    logic [16:0] r_lfsr;
    logic [9:0]  r_pcm;
    logic [15:0] w_acc_nx;
    logic        w_ce;
    logic        w_tick8;
    logic        w_tick16;
    logic [11:0] w_tp [3];
    logic [11:0] w_tmax [3];
    logic [3:0]  w_vol [3];
    logic [7:0]  w_chv [3];
    logic [2:0]  w_on;
    logic [4:0]  w_nmax;
    logic [3:0]  w_env;
    logic        w_env_restart;
    logic [3:0]  w_env_shape;

    assign w_acc_nx      = r_acc + 16'(FREQ);
    assign w_ce          = w_acc_nx >= 16'(FREF);
    assign w_tick8       = w_ce && (r_pre[2:0] == 3'd7);
    assign w_tick16      = w_ce && (r_pre == 4'd15);
    assign w_nmax        = (r_regs[AY_NOISE][4:0] == 5'd0) ? 5'd1 : r_regs[AY_NOISE][4:0];
    assign w_env_restart = ay_req && (ay_reg == AY_ENV_SHAPE);
    assign w_env_shape   = w_env_restart ? ay_data_o[3:0] : r_regs[AY_ENV_SHAPE][3:0];
    assign ay_data_i     = (ay_reg >= AY_IO_A) ? 8'hFF : (r_regs[ay_reg] & ay_mask(ay_reg));
    assign pcm           = r_pcm;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        assign w_tp[g]   = {r_regs[2*g+1][3:0], r_regs[2*g]};
        assign w_tmax[g] = (w_tp[g] == 12'd0) ? 12'd1 : w_tp[g];
        assign w_vol[g]  = r_regs[AY_AMP_A+g][4] ? w_env : r_regs[AY_AMP_A+g][3:0];
        assign w_on[g]   = (r_tone[g] | r_regs[AY_MIXER][g]) & (r_lfsr[0] | r_regs[AY_MIXER][g+3]);
        assign w_chv[g]  = w_on[g] ? ay_dac(w_vol[g]) : 8'd0;
    end

    // Fractional divider produces the 1.75 MHz enable; prescaler derives the /8 and /16 ticks
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc <= '0;
            r_pre <= '0;
        end else begin
            r_acc <= w_ce ? w_acc_nx - 16'(FREF) : w_acc_nx;
            if (w_ce) r_pre <= r_pre + 4'd1;
        end
    end

    // CPU writes land immediately, regardless of the generator enable
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (ay_req) begin
            r_regs[ay_reg] <= ay_data_o;
        end
    end

    // Tone counters; >= lets a shortened period wrap at once instead of running to 4095
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tone <= '0;
            for (int c = 0; c < 3; c++) r_tcnt[c] <= '0;
        end else if (w_tick8) begin
            for (int c = 0; c < 3; c++) begin
                if ({1'b0, r_tcnt[c]} + 13'd1 >= {1'b0, w_tmax[c]}) begin
                    r_tcnt[c] <= '0;
                    r_tone[c] <= ~r_tone[c];
                end else begin
                    r_tcnt[c] <= r_tcnt[c] + 12'd1;
                end
            end
        end
    end

    // Noise period counter shifts the 17-bit LFSR on each wrap
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ncnt <= '0;
            r_lfsr <= 17'h1;
        end else if (w_tick16) begin
            if ({1'b0, r_ncnt} + 6'd1 >= {1'b0, w_nmax}) begin
                r_ncnt <= '0;
                r_lfsr <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
            end else begin
                r_ncnt <= r_ncnt + 5'd1;
            end
        end
    end

    ay_envelope u_env (
        .clock     (clock),
        .reset     (reset),
        .i_tick16  (w_tick16),
        .i_period  ({r_regs[AY_ENV_H], r_regs[AY_ENV_L]}),
        .i_shape   (w_env_shape),
        .i_restart (w_env_restart),
        .o_level   (w_env)
    );

    // Registered mix of the three channel DAC values
    always_ff @(posedge clock) begin
        if (reset) r_pcm <= '0;
        else       r_pcm <= {2'b0, w_chv[0]} + {2'b0, w_chv[1]} + {2'b0, w_chv[2]};
    end
endmodule

// File: tb/tb_ay8910.sv
// tb_ay8910: randomized bench for ay8910 against a cycle-level behavioural model
module tb_ay8910;
    localparam int FREQ = 7;
    localparam int FREF = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ay_req = 1'b0;
    logic [3:0] ay_reg = 4'd0;
    logic [7:0] ay_data_o = 8'd0;
    logic [7:0] ay_data_i;
    logic [9:0] pcm;

    ay8910 #(.FREQ(FREQ), .FREF(FREF)) dut (
        .clock     (clock),
        .reset     (reset),
        .ay_reg    (ay_reg),
        .ay_data_o (ay_data_o),
        .ay_req    (ay_req),
        .ay_data_i (ay_data_i),
        .pcm       (pcm)
    );

    always #20 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int pk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int dac [16] = '{0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 181, 255};
    int msk [16] = '{255, 15, 255, 15, 255, 15, 31, 63, 31, 31, 31, 255, 255, 15, 0, 0};

    logic [7:0]  m_r [16];
    logic [16:0] m_lfsr;
    logic        m_tone [3];
    int m_acc, m_pre, m_ncnt, m_ecnt, m_k, m_pcm;
    int m_tcnt [3];

    function automatic int m_rd(input int a);
        return (a >= 14) ? 255 : int'(m_r[a]) & msk[a];
    endfunction

    function automatic int maxp(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    // Envelope level from shape and number of period wraps since the last restart
    function automatic int env_lvl();
        int sh = int'(m_r[13]) % 16;
        int s = m_k % 16;
        int p = m_k / 16;
        bit att = sh[2];
        if (m_k < 16) return att ? s : 15 - s;
        if (!sh[3]) return 0;
        if (sh[0]) return (att ^ sh[1]) ? 15 : 0;
        if (sh[1]) return (att ^ p[0]) ? s : 15 - s;
        return att ? s : 15 - s;
    endfunction

    function automatic int mix();
        int s = 0;
        for (int c = 0; c < 3; c++) begin
            int vol = m_r[8+c][4] ? env_lvl() : int'(m_r[8+c][3:0]);
            if ((m_tone[c] | m_r[7][c]) && (m_lfsr[0] | m_r[7][c+3])) s += dac[vol];
        end
        return s;
    endfunction

    task automatic model_clk();
        bit ce, t8, t16, ewrap;
        int npcm;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_r[i] = 8'd0;
            for (int c = 0; c < 3; c++) begin m_tone[c] = 1'b0; m_tcnt[c] = 0; end
            m_lfsr = 17'h1;
            {m_acc, m_pre, m_ncnt, m_ecnt, m_k, m_pcm} = '0;
            return;
        end
        npcm = mix();
        ce = (m_acc + FREQ) >= FREF;
        m_acc = ce ? m_acc + FREQ - FREF : m_acc + FREQ;
        t8 = ce && (m_pre % 8 == 7);
        t16 = ce && (m_pre == 15);
        if (ce) m_pre = (m_pre + 1) % 16;
        ewrap = 1'b0;
        if (t8)
            for (int c = 0; c < 3; c++) begin
                int tp = (int'(m_r[2*c+1]) % 16) * 256 + int'(m_r[2*c]);
                if (m_tcnt[c] + 1 >= maxp(tp)) begin m_tcnt[c] = 0; m_tone[c] = ~m_tone[c]; end
                else m_tcnt[c]++;
            end
        if (t16) begin
            if (m_ncnt + 1 >= maxp(int'(m_r[6]) % 32)) begin
                m_ncnt = 0;
                m_lfsr = {m_lfsr[0] ^ m_lfsr[3], m_lfsr[16:1]};
            end else m_ncnt++;
            if (m_ecnt + 1 >= maxp(int'(m_r[12]) * 256 + int'(m_r[11]))) begin
                m_ecnt = 0;
                ewrap = 1'b1;
            end else m_ecnt++;
        end
        if (ay_req) m_r[ay_reg] = ay_data_o;
        if (ay_req && ay_reg == 4'd13) m_k = 0;
        else if (ewrap) m_k++;
        m_pcm = npcm;
    endtask

    task automatic cyc(input logic rq, input logic [3:0] a, input logic [7:0] d);
        ay_req = rq;
        ay_reg = a;
        ay_data_o = d;
        @(posedge clock);
        model_clk();
        @(negedge clock);
        ay_req = 1'b0;
        chk("pcm", pcm, m_pcm);
        chk("rdbk", ay_data_i, m_rd(int'(ay_reg)));
        if (int'(pcm) > pk) pk = int'(pcm);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cyc(1'b1, a, d);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0, 4'($urandom_range(0, 15)), 8'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        ay_req = 1'b0;
        ay_reg = a;
        #1;
        chk($sformatf("rd_r%0d", a), ay_data_i, m_rd(int'(a)));
    endtask

    task automatic rst();
        reset = 1'b1;
        repeat (2) cyc(1'b0, 4'd0, 8'd0);
        reset = 1'b0;
    endtask

    task automatic rnd_wr();
        logic [3:0] a = 4'($urandom_range(0, 15));
        logic [7:0] d = 8'($urandom_range(0, 255));
        if (a == 4'd1 || a == 4'd3 || a == 4'd5 || a == 4'd12) d = 8'd0;
        if (a == 4'd11) d = d % 8'd4;
        wr(a, d);
    endtask

    initial begin
        repeat (3) cyc(1'b0, 4'd0, 8'd0);
        reset = 1'b0;
        for (int a = 0; a < 16; a++) rd(4'(a));
        chk("pcm_rst", pcm, 0);
        wr(4'd1, 8'hFF);  rd(4'd1);
        wr(4'd6, 8'hFF);  rd(4'd6);
        wr(4'd8, 8'hFF);  rd(4'd8);
        wr(4'd13, 8'hFF); rd(4'd13);
        chk("mask_r13", ay_data_i, 8'h0F);
        for (int a = 0; a < 16; a++) wr(4'(a), 8'($urandom_range(0, 255)));
        for (int a = 0; a < 16; a++) rd(4'(a));
        rst();
        wr(4'd0, 8'd4); wr(4'd1, 8'd0); wr(4'd7, 8'h3E); wr(4'd8, 8'h0F);
        run(1600);
        rst();
        wr(4'd6, 8'd0); wr(4'd7, 8'h37); wr(4'd9, 8'h0F);
        run(4200);
        rst();
        wr(4'd4, 8'd0); wr(4'd5, 8'd0); wr(4'd7, 8'h3B); wr(4'd10, 8'h10);
        wr(4'd11, 8'd1); wr(4'd12, 8'd0); wr(4'd13, 8'h0D);
        pk = 0;
        run(5000);
        chk("env_peak", pk, 255);
        wr(4'd13, 8'h0E);
        run(8000);
        run($urandom_range(300, 1500));
        wr(4'd13, 8'h0E);
        run(3000);
        for (int i = 0; i < 16000; i++) begin
            if (i == 8000) rst();
            if ($urandom_range(0, 40) == 0) rnd_wr();
            else run(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
